sample_block_counter: RTL and testbench
=======================================

Name: sample_block_counter

Overview:
Counts incoming sample strobes and flags each completed block of N samples. N is programmable at run time; 0 selects a default size.
- Successor to the fixed 1000-sample counter wrapper. Adds a run-time block size, two flag-release modes, an overrun detector, a running sample index and a completed-block tally.
- Sits between the sample-ready logic (cnt_up source) and the block-processing controller / host status register.

Parameters:
NUM_BITS, 10, width of sample_count and block_size
DEFAULT_BLOCK, 1000, block length used when block_size == 0; must be < 2**NUM_BITS
HOLD_MODE, 0, 0 = block_done released by the next non-completing cnt_up (legacy); 1 = block_done held until blk_ack
TALLY_BITS, 8, width of block_total

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
cnt_up  in  1  one-cycle strobe: one sample accepted
clear  in  1  synchronous clear of all state
block_size  in  NUM_BITS  requested block length; 0 = DEFAULT_BLOCK
blk_ack  in  1  acknowledge of block_done (used only when HOLD_MODE=1)
sample_count  out  NUM_BITS  index of the next sample within the current block, 0..N-1
block_done  out  1  sticky block-complete flag
block_pulse  out  1  one-cycle pulse per completed block
overrun  out  1  sticky: a block completed while block_done was still set
block_total  out  TALLY_BITS  completed-block count, wraps modulo 2**TALLY_BITS

Behaviour:
Reset (n_reset low, async):
- All outputs 0.
- Latched size size_q = eff(block_size) at release; eff(x) = (x == 0) ? DEFAULT_BLOCK : x.

Size latching:
- size_q reloads from eff(block_size) only when a block boundary occurs or clear is asserted.
- Changes to block_size mid-block do not affect the current block.

Counting, per rising edge, in priority order:
1. clear = 1:
   - sample_count, block_done, block_pulse, overrun and block_total go to 0.
   - size_q reloads.
   - cnt_up in the same cycle is ignored.
2. cnt_up = 1 and sample_count == size_q - 1 (completion):
   - sample_count -> 0; block_pulse -> 1 (next cycle only).
   - block_total increments; size_q reloads.
   - block_done -> 1.
   - If HOLD_MODE = 1 and block_done was already 1 and blk_ack = 0 this cycle: overrun -> 1.
3. cnt_up = 1, not completing:
   - sample_count increments.
   - HOLD_MODE = 0: block_done -> 0.
4. Otherwise sample_count holds.

Flag release:
- HOLD_MODE = 1: blk_ack = 1 with no completion in the same cycle clears block_done next cycle.
- Completion and blk_ack in the same cycle: block_done stays 1, no overrun.
- HOLD_MODE = 0: blk_ack is ignored; overrun never sets.

Timing and boundaries:
- Latency: block_done and block_pulse rise on the clock edge that samples the N-th cnt_up, i.e. visible the cycle after the strobe.
- block_pulse is 0 on every cycle without a completion.
- Size 1: every cnt_up completes a block; block_pulse stays high for consecutive strobes; sample_count stays 0.
- block_total wraps 2**TALLY_BITS-1 -> 0 silently.
- block_size > 2**NUM_BITS-1 is impossible by width. Values below the current sample_count cannot occur because size_q is latched.
- Async reset mid-block discards the partial count. No state survives except the re-latched size.

Decomposition:
- Package sample_block_pkg: MODE_RELEASE_ON_CNT = 0 and MODE_HOLD_UNTIL_ACK = 1 constants, and the default-size constant.
- Datapath counter: one instance of the existing flex_counter (NUM_BITS).
  - rollover_val = size_q; count_enable = cnt_up; clear = clear.
  - Completion is detected locally as cnt_up && count == size_q - 1, not from the delayed rollover_flag, so latency is exact.
  - Alternatively the counter may be implemented inline.
- Flag, overrun, tally and size-latch logic are local to the block.

Test Plan:
1. Defaults, block_size = 0, HOLD_MODE = 0, 1000 cnt_up strobes with gaps:
   - block_pulse high for exactly 1 cycle after strobe 1000; sample_count = 0; block_total = 1.
   - block_done stays high through idle cycles and drops after strobe 1001; sample_count = 1.
2. block_size = 5, HOLD_MODE = 1, 5 strobes, then 5 more with no ack:
   - block_done = 1 after strobe 5; overrun = 1 after strobe 10; block_total = 2.
   - blk_ack then clears block_done; overrun stays 1 until clear.
3. block_size changed 8 -> 3 after strobe 4 of an 8-block:
   - The current block completes at strobe 8.
   - The next block completes 3 strobes later (strobe 11).
4. clear and cnt_up asserted together at sample_count = 6:
   - All outputs 0 next cycle; the strobe is not counted.
5. block_size = 1, cnt_up held high 4 cycles:
   - block_pulse high 4 consecutive cycles; block_total = 4; sample_count stays 0.
6. n_reset pulsed low mid-clock at sample_count = 300:
   - All outputs 0 immediately, without waiting for a clock edge.
   - Counting resumes from 0 after release; the next completion occurs after N further strobes.

Source files
------------

// File: rtl/sample_block_pkg.sv
// -----------------------------------------------------------------------------
// sample_block_pkg
// Shared constants for the sample block counter: flag-release mode encodings
// and the block length used when the requested size is zero.
// -----------------------------------------------------------------------------
package sample_block_pkg;

  // block_done is cleared by the next non-completing cnt_up (legacy behaviour).
  localparam int MODE_RELEASE_ON_CNT = 0;
  // block_done stays set until the consumer acknowledges with blk_ack.
  localparam int MODE_HOLD_UNTIL_ACK = 1;

  // Block length selected by block_size == 0.
  localparam int DEFAULT_BLOCK_SIZE = 1000;

endpackage : sample_block_pkg

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Modulo counter that counts 0 .. rollover_val-1 on count_enable and wraps to
// 0. rollover_flag is a registered one-cycle pulse that follows each wrap.
//
// Ports:
//   clk           in   system clock, rising edge
//   n_reset       in   asynchronous active-low reset
//   clear         in   synchronous clear, overrides count_enable
//   count_enable  in   advance the count by one
//   rollover_val  in   modulus (must be >= 1)
//   count_out     out  current count
//   rollover_flag out  high for the cycle after the count wrapped
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_BITS = 10
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic wrap;

  assign wrap = count_enable && (count_out == rollover_val - NUM_BITS'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (wrap) begin
      count_out     <= '0;
      rollover_flag <= 1'b1;
    end else begin
      rollover_flag <= 1'b0;
      if (count_enable) begin
        count_out <= count_out + NUM_BITS'(1);
      end
    end
  end

endmodule : flex_counter

// File: rtl/sample_block_counter.sv
// -----------------------------------------------------------------------------
// sample_block_counter
// Counts sample strobes and flags each completed block of N samples. N is
// latched from block_size (0 selects DEFAULT_BLOCK) at reset release, on every
// block boundary and on clear, so mid-block size changes wait for the boundary.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_reset      in   asynchronous active-low reset
//   cnt_up       in   one-cycle strobe: one sample accepted
//   clear        in   synchronous clear of all state (wins over cnt_up)
//   block_size   in   requested block length, 0 = DEFAULT_BLOCK
//   blk_ack      in   acknowledge of block_done (HOLD_MODE = 1 only)
//   sample_count out  index of the next sample in the current block
//   block_done   out  sticky block-complete flag
//   block_pulse  out  one-cycle pulse per completed block
//   overrun      out  sticky: a block completed while block_done was still set
//   block_total  out  completed-block count, wraps silently
// -----------------------------------------------------------------------------
module sample_block_counter
  import sample_block_pkg::*;
#(
  parameter int NUM_BITS      = 10,
  parameter int DEFAULT_BLOCK = DEFAULT_BLOCK_SIZE,
  parameter int HOLD_MODE     = MODE_RELEASE_ON_CNT,
  parameter int TALLY_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  cnt_up,
  input  logic                  clear,
  input  logic [NUM_BITS-1:0]   block_size,
  input  logic                  blk_ack,
  output logic [NUM_BITS-1:0]   sample_count,
  output logic                  block_done,
  output logic                  block_pulse,
  output logic                  overrun,
  output logic [TALLY_BITS-1:0] block_total
);

  localparam bit HOLD = (HOLD_MODE == MODE_HOLD_UNTIL_ACK);

  logic [NUM_BITS-1:0] size_q;
  logic                size_valid;
  logic [NUM_BITS-1:0] eff_size;
  logic [NUM_BITS-1:0] size_cur;
  logic                complete;

  assign eff_size = (block_size == '0) ? NUM_BITS'(DEFAULT_BLOCK) : block_size;

  // Until the first edge after reset release the size register is not yet
  // loaded, so the live requested size stands in for it; that edge latches it.
  assign size_cur = size_valid ? size_q : eff_size;

  // Completion is decoded here rather than from the counter's registered
  // rollover flag so block_done and the tally move on the N-th strobe's edge.
  assign complete = cnt_up && !clear && (sample_count == size_cur - NUM_BITS'(1));

  flex_counter #(
    .NUM_BITS (NUM_BITS)
  ) u_counter (
    .clk           (clk),
    .n_reset       (n_reset),
    .clear         (clear),
    .count_enable  (cnt_up),
    .rollover_val  (size_cur),
    .count_out     (sample_count),
    .rollover_flag (block_pulse)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      size_q      <= '0;
      size_valid  <= 1'b0;
      block_done  <= 1'b0;
      overrun     <= 1'b0;
      block_total <= '0;
    end else if (clear) begin
      size_q      <= eff_size;
      size_valid  <= 1'b1;
      block_done  <= 1'b0;
      overrun     <= 1'b0;
      block_total <= '0;
    end else begin
      size_valid <= 1'b1;
      if (complete) begin
        size_q      <= eff_size;
        block_total <= block_total + TALLY_BITS'(1);
        block_done  <= 1'b1;
        // An ack arriving with the completion consumes the old flag in time.
        if (HOLD && block_done && !blk_ack) begin
          overrun <= 1'b1;
        end
      end else begin
        size_q <= size_cur;
        if (!HOLD && cnt_up) begin
          block_done <= 1'b0;
        end
        if (HOLD && blk_ack) begin
          block_done <= 1'b0;
        end
      end
    end
  end

endmodule : sample_block_counter

// File: tb/tb_sample_block_counter.sv
// -----------------------------------------------------------------------------
// tb_sample_block_counter
// Drives one release-on-count instance and one hold-until-ack instance from
// shared stimulus. A reference model predicts both outputs each cycle and
// queues them; the queue is drained after the clock edge and compared, with
// extra directed checks at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_sample_block_counter;

  localparam int NB  = 10;
  localparam int TB  = 8;
  localparam int DEF = 1000;

  typedef struct {
    int sc    [2];
    int done  [2];
    int pulse [2];
    int ovr   [2];
    int tot   [2];
  } exp_t;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          cnt_up;
  logic          clear;
  logic [NB-1:0] block_size;
  logic          blk_ack;

  logic [NB-1:0] r_sc,  h_sc;
  logic          r_done, h_done, r_pulse, h_pulse, r_ovr, h_ovr;
  logic [TB-1:0] r_tot, h_tot;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, index 0 = release mode, 1 = hold mode.
  int m_sc [2], m_done [2], m_pulse [2], m_ovr [2], m_tot [2], m_size [2];
  exp_t sb_q [$];

  sample_block_counter #(.NUM_BITS(NB), .DEFAULT_BLOCK(DEF), .HOLD_MODE(0), .TALLY_BITS(TB)) dut_rel (
    .clk(clk), .n_reset(n_reset), .cnt_up(cnt_up), .clear(clear),
    .block_size(block_size), .blk_ack(blk_ack),
    .sample_count(r_sc), .block_done(r_done), .block_pulse(r_pulse),
    .overrun(r_ovr), .block_total(r_tot));

  sample_block_counter #(.NUM_BITS(NB), .DEFAULT_BLOCK(DEF), .HOLD_MODE(1), .TALLY_BITS(TB)) dut_hold (
    .clk(clk), .n_reset(n_reset), .cnt_up(cnt_up), .clear(clear),
    .block_size(block_size), .blk_ack(blk_ack),
    .sample_count(h_sc), .block_done(h_done), .block_pulse(h_pulse),
    .overrun(h_ovr), .block_total(h_tot));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int bs);
    return (bs == 0) ? DEF : bs;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sc[m] = 0; m_done[m] = 0; m_pulse[m] = 0; m_ovr[m] = 0; m_tot[m] = 0;
      m_size[m] = eff(int'(block_size));
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    exp_t e;
    int   comp;
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        m_sc[m] = 0; m_done[m] = 0; m_pulse[m] = 0; m_ovr[m] = 0; m_tot[m] = 0;
        m_size[m] = eff(int'(block_size));
      end else begin
        comp = (cnt_up && (m_sc[m] == m_size[m] - 1)) ? 1 : 0;
        m_pulse[m] = comp;
        if (comp != 0) begin
          if (m == 1 && m_done[m] == 1 && !blk_ack) m_ovr[m] = 1;
          m_sc[m]   = 0;
          m_done[m] = 1;
          m_tot[m]  = (m_tot[m] + 1) % (1 << TB);
          m_size[m] = eff(int'(block_size));
        end else begin
          if (cnt_up) m_sc[m] = m_sc[m] + 1;
          if (m == 0 && cnt_up) m_done[m] = 0;
          if (m == 1 && blk_ack) m_done[m] = 0;
        end
      end
      e.sc[m] = m_sc[m]; e.done[m] = m_done[m]; e.pulse[m] = m_pulse[m];
      e.ovr[m] = m_ovr[m]; e.tot[m] = m_tot[m];
    end
    sb_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check("rel.sample_count", int'(r_sc),    e.sc[0]);
    check("rel.block_done",   int'(r_done),  e.done[0]);
    check("rel.block_pulse",  int'(r_pulse), e.pulse[0]);
    check("rel.overrun",      int'(r_ovr),   e.ovr[0]);
    check("rel.block_total",  int'(r_tot),   e.tot[0]);
    check("hold.sample_count", int'(h_sc),    e.sc[1]);
    check("hold.block_done",   int'(h_done),  e.done[1]);
    check("hold.block_pulse",  int'(h_pulse), e.pulse[1]);
    check("hold.overrun",      int'(h_ovr),   e.ovr[1]);
    check("hold.block_total",  int'(h_tot),   e.tot[1]);
  endtask

  // One clock: inputs are driven just after a falling edge, the model
  // prediction is queued, and outputs are checked on the next falling edge.
  task automatic cycle(input logic cu, input logic cl, input logic ak, input int bs);
    cnt_up = cu; clear = cl; blk_ack = ak; block_size = NB'(bs);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic strobes(input int n, input int bs);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, bs);
  endtask

  initial begin
    n_reset = 1'b0; cnt_up = 1'b0; clear = 1'b0; blk_ack = 1'b0; block_size = '0;
    #2;
    check("reset.rel_done",  int'(r_done), 0);
    check("reset.hold_tot",  int'(h_tot),  0);
    check("reset.rel_sc",    int'(r_sc),   0);
    #10 n_reset = 1'b1;
    model_reset();
    @(negedge clk);

    // 1: default size, release mode, strobes with gaps.
    for (int i = 1; i <= 1000; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0);
      if (i % 7 == 0) cycle(1'b0, 1'b0, 1'b0, 0);
      if (i == 999) check("t1.no_pulse_999", int'(r_pulse), 0);
    end
    check("t1.pulse_1000", int'(r_pulse), 1);
    check("t1.sc_1000",    int'(r_sc),    0);
    check("t1.tot_1000",   int'(r_tot),   1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0);
    check("t1.pulse_idle", int'(r_pulse), 0);
    check("t1.done_idle",  int'(r_done),  1);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t1.done_1001",  int'(r_done),  0);
    check("t1.sc_1001",    int'(r_sc),    1);
    check("t1.hold_done_1001", int'(h_done), 1);

    // 2: size 5, hold mode overrun and acknowledge.
    cycle(1'b0, 1'b1, 1'b0, 5);
    strobes(5, 5);
    check("t2.hold_done_5", int'(h_done), 1);
    check("t2.hold_ovr_5",  int'(h_ovr),  0);
    strobes(5, 5);
    check("t2.hold_ovr_10", int'(h_ovr),  1);
    check("t2.hold_tot_10", int'(h_tot),  2);
    check("t2.rel_ovr_10",  int'(r_ovr),  0);
    cycle(1'b0, 1'b0, 1'b1, 5);
    check("t2.hold_done_ack", int'(h_done), 0);
    check("t2.hold_ovr_ack",  int'(h_ovr),  1);
    cycle(1'b0, 1'b0, 1'b0, 5);
    check("t2.hold_ovr_sticky", int'(h_ovr), 1);
    // Completion together with ack: flag stays, no new overrun source.
    strobes(4, 5);
    cnt_up = 1'b1; clear = 1'b0; blk_ack = 1'b1; block_size = NB'(5);
    model_step();
    @(negedge clk);
    compare_outputs();
    check("t2.hold_done_ack_comp", int'(h_done), 1);

    // 3: size change mid-block is deferred to the boundary.
    cycle(1'b0, 1'b1, 1'b0, 8);
    strobes(4, 8);
    strobes(3, 3);
    check("t3.no_pulse_7", int'(r_pulse), 0);
    strobes(1, 3);
    check("t3.pulse_8",    int'(r_pulse), 1);
    strobes(2, 3);
    check("t3.no_pulse_10", int'(r_pulse), 0);
    strobes(1, 3);
    check("t3.pulse_11",   int'(r_pulse), 1);
    check("t3.tot_11",     int'(r_tot),   2);

    // 4: clear wins over a simultaneous strobe.
    cycle(1'b0, 1'b1, 1'b0, 8);
    strobes(6, 8);
    check("t4.sc_6", int'(r_sc), 6);
    cycle(1'b1, 1'b1, 1'b0, 8);
    check("t4.sc_clr",  int'(r_sc),  0);
    check("t4.tot_clr", int'(h_tot), 0);

    // 5: size 1, continuous strobes, then tally wrap.
    cycle(1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1);
      check("t5.pulse_run", int'(r_pulse), 1);
    end
    check("t5.tot_4", int'(r_tot), 4);
    check("t5.sc_0",  int'(r_sc),  0);
    cycle(1'b0, 1'b0, 1'b0, 1);
    check("t5.pulse_gap", int'(r_pulse), 0);
    strobes(251, 1);
    check("t5.tot_255", int'(r_tot), 255);
    strobes(1, 1);
    check("t5.tot_wrap", int'(r_tot), 0);

    // 6: asynchronous reset mid-block.
    cycle(1'b0, 1'b1, 1'b0, 0);
    strobes(300, 0);
    check("t6.sc_300", int'(r_sc), 300);
    cnt_up = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    check("t6.async_sc",   int'(r_sc),   0);
    check("t6.async_tot",  int'(h_tot),  0);
    check("t6.async_done", int'(h_done), 0);
    #1 n_reset = 1'b1;
    model_reset();
    @(negedge clk);
    strobes(999, 0);
    check("t6.no_pulse_999", int'(r_pulse), 0);
    strobes(1, 0);
    check("t6.pulse_1000", int'(r_pulse), 1);
    check("t6.tot_1000",   int'(r_tot),   1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sample_block_counter
